// File: rtl/logic_unit_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter_pkg
//   Shared definitions for the logic-unit arbiter:
//     - op-code encodings of the bitwise logic unit (LU_AND/LU_OR/LU_XOR/LU_NAND)
//     - arbiter FSM state encodings (S_IDLE/S_EXEC/S_RESP, 2 bits)
//   No ports (package).
// ---------------------------------------------------------------------------
package logic_unit_arbiter_pkg;

   typedef logic [1:0] lu_op_t;
   typedef logic [1:0] lu_state_t;

   // Bitwise op codes, applied across the full operand width (no carry chain).
   localparam lu_op_t LU_AND  = 2'b00;
   localparam lu_op_t LU_OR   = 2'b01;
   localparam lu_op_t LU_XOR  = 2'b10;
   localparam lu_op_t LU_NAND = 2'b11;

   // Arbiter FSM encodings; 2'b11 is unused and recovers to idle.
   localparam lu_state_t S_IDLE = 2'b00;
   localparam lu_state_t S_EXEC = 2'b01;
   localparam lu_state_t S_RESP = 2'b10;

endpackage

// File: rtl/logic_unit_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Selects the first asserted request at
//   or above ptr_i, wrapping from N_REQ-1 back to 0.
//   Ports:
//     req_i   in  N_REQ  request vector
//     ptr_i   in  ID_W   highest-priority index for this pick
//     gnt_o   out N_REQ  one-hot winner (all zero when no request)
//     idx_o   out ID_W   index of the winner (0 when no request)
//     any_o   out 1      at least one request is asserted
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]  idx_o,
   output logic             any_o
);

   // Walk the offsets from farthest to nearest so the closest request to
   // ptr_i is the last one written and therefore wins.
   always_comb begin
      int j;
      j     = 0;
      gnt_o = '0;
      idx_o = '0;
      any_o = |req_i;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = (int'(ptr_i) + k) % N_REQ;
         if (req_i[j]) begin
            gnt_o    = '0;
            gnt_o[j] = 1'b1;
            idx_o    = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
//   Shares one bitwise logic unit (AND/OR/XOR/NAND, WIDTH bits) between
//   N_REQ requesters with round-robin arbitration. The winner's op code and
//   operands are captured at grant, the result is computed in EXEC and
//   presented registered with the owner's id.
//   Optional build macro: LU_STATS_EN adds a saturating 16-bit grant counter
//   on output grant_cnt.
//   Ports:
//     clk        in   1            rising-edge clock
//     rst_n      in   1            synchronous reset, active low
//     req        in   N_REQ        per-requester request, held until gnt seen
//     op         in   2*N_REQ      per-requester op code, slice i = op[2i+1:2i]
//     a_in       in   WIDTH*N_REQ  per-requester operand A
//     b_in       in   WIDTH*N_REQ  per-requester operand B
//     gnt        out  N_REQ        one-hot grant, single-cycle pulse
//     res        out  WIDTH        result of the granted operation
//     res_valid  out  1            one-cycle pulse qualifying res/res_id
//     res_id     out  ID_W         requester that owns res
//     busy       out  1            FSM is not idle
//     grant_cnt  out  16           (LU_STATS_EN only) saturating grant count
// ---------------------------------------------------------------------------
module logic_unit_arbiter
   import logic_unit_arbiter_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int WIDTH = 8,
   localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [2*N_REQ-1:0]     op,
   input  logic [WIDTH*N_REQ-1:0] a_in,
   input  logic [WIDTH*N_REQ-1:0] b_in,
   output logic [N_REQ-1:0]       gnt,
   output logic [WIDTH-1:0]       res,
   output logic                   res_valid,
   output logic [ID_W-1:0]        res_id,
   output logic                   busy
`ifdef LU_STATS_EN
   ,output logic [15:0]           grant_cnt
`endif
);

   // Per-requester views of the flattened input buses.
   logic [N_REQ-1:0][1:0]       op_arr;
   logic [N_REQ-1:0][WIDTH-1:0] a_arr;
   logic [N_REQ-1:0][WIDTH-1:0] b_arr;

   assign op_arr = op;
   assign a_arr  = a_in;
   assign b_arr  = b_in;

   lu_state_t         state_q, state_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              res_valid_q, res_valid_d;
   logic [ID_W-1:0]   res_id_q, res_id_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   lu_op_t            opr_op_q, opr_op_d;
   logic [WIDTH-1:0]  opr_a_q, opr_a_d;
   logic [WIDTH-1:0]  opr_b_q, opr_b_d;

   logic [N_REQ-1:0]  pick_oh;
   logic [ID_W-1:0]   pick_idx;
   logic              pick_any;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (pick_oh),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   function automatic logic [WIDTH-1:0] lu_eval(input lu_op_t o,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] r;
      case (o)
         LU_AND:  r = x & y;
         LU_OR:   r = x | y;
         LU_XOR:  r = x ^ y;
         LU_NAND: r = ~(x & y);
      endcase
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      gnt_d       = '0;
      res_d       = res_q;
      res_valid_d = 1'b0;
      res_id_d    = res_id_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      opr_op_d    = opr_op_q;
      opr_a_d     = opr_a_q;
      opr_b_d     = opr_b_q;
      case (state_q)
         S_IDLE: begin
            if (pick_any) begin
               // Operands are frozen here so later changes on the bus
               // cannot disturb the result.
               gnt_d    = pick_oh;
               opr_op_d = op_arr[pick_idx];
               opr_a_d  = a_arr[pick_idx];
               opr_b_d  = b_arr[pick_idx];
               id_d     = pick_idx;
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            res_d       = lu_eval(opr_op_q, opr_a_q, opr_b_q);
            res_id_d    = id_q;
            res_valid_d = 1'b1;
            state_d     = S_RESP;
         end
         S_RESP: begin
            // Priority moves just past the requester that was served.
            ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         gnt_q       <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         ptr_q       <= '0;
         id_q        <= '0;
         opr_op_q    <= LU_AND;
         opr_a_q     <= '0;
         opr_b_q     <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         opr_op_q    <= opr_op_d;
         opr_a_q     <= opr_a_d;
         opr_b_q     <= opr_b_d;
      end
   end

   assign gnt       = gnt_q;
   assign res       = res_q;
   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign busy      = (state_q != S_IDLE);

`ifdef LU_STATS_EN
   logic [15:0] grant_cnt_q, grant_cnt_d;

   // Counted on the edge that raises gnt, so the count moves with the pulse.
   always_comb begin
      grant_cnt_d = grant_cnt_q;
      if ((|gnt_d) && (grant_cnt_q != 16'hFFFF))
         grant_cnt_d = grant_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) grant_cnt_q <= '0;
      else        grant_cnt_q <= grant_cnt_d;
   end

   assign grant_cnt = grant_cnt_q;
`endif

endmodule
